// File: rtl/iss_hazard_ctrl_if.sv
// Issue/EX/WB hazard-control bus: issue-stage operands, EX/WB destinations,
// redirect, and the stall/flush/forward controls returned to the pipeline.
interface iss_hazard_ctrl_if;
   logic       iss_valid;
   logic [3:0] iss_rs1_addr;
   logic [3:0] iss_rs2_addr;
   logic [3:0] iss_rd_addr;
   logic       iss_rs1_use;
   logic       iss_rs2_use;
   logic       iss_we;
   logic       iss_multi;
   logic [3:0] ex_rd_addr;
   logic       ex_we;
   logic       wb_we;
   logic [3:0] wb_rd_addr;
   logic       redirect;
   logic       iss_stall;
   logic       ex_stall;
   logic       ex_flush;
   logic       fwd_rs1;
   logic       fwd_rs2;
   logic       busy;

   modport master (
      output iss_valid, iss_rs1_addr, iss_rs2_addr, iss_rd_addr,
      output iss_rs1_use, iss_rs2_use, iss_we, iss_multi,
      output ex_rd_addr, ex_we, wb_we, wb_rd_addr, redirect,
      input  iss_stall, ex_stall, ex_flush, fwd_rs1, fwd_rs2, busy
   );

   modport slave (
      input  iss_valid, iss_rs1_addr, iss_rs2_addr, iss_rd_addr,
      input  iss_rs1_use, iss_rs2_use, iss_we, iss_multi,
      input  ex_rd_addr, ex_we, wb_we, wb_rd_addr, redirect,
      output iss_stall, ex_stall, ex_flush, fwd_rs1, fwd_rs2, busy
   );
endinterface

// File: rtl/iss_hazard_ctrl.sv
// Issue-stage hazard controller: register scoreboard, multi-cycle EX occupancy
// FSM and redirect flush. Optional EX->ISS forwarding enabled by QTPA_FWD_EN.
module iss_hazard_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MUL_LAT    = 4
) (
   input logic              clk,
   input logic              rst_n,
   iss_hazard_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned NREG  = 16;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   // DATA_WIDTH only tracks the shared package value; MUL_LAT must fit the counter
   if (MUL_LAT < 2 || MUL_LAT > 15 || DATA_WIDTH == 0) begin : g_param_chk
      $error("iss_hazard_ctrl: MUL_LAT must be 2..15");
   end

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_pend;
   logic              w_pend_nxt;
   logic [NREG-1:0]   r_sb;
   logic [NREG-1:0]   w_sb_nxt;

   logic w_ex_stall;
   logic w_fwd_rs1;
   logic w_fwd_rs2;
   logic w_hazard;
   logic w_redir_eff;
   logic w_iss_stall;
   logic w_accept;

   assign w_ex_stall = (r_state == BUSY);

`ifdef QTPA_FWD_EN
   assign w_fwd_rs1 = bus.iss_rs1_use & bus.ex_we &
                      (bus.ex_rd_addr == bus.iss_rs1_addr) & ~w_ex_stall;
   assign w_fwd_rs2 = bus.iss_rs2_use & bus.ex_we &
                      (bus.ex_rd_addr == bus.iss_rs2_addr) & ~w_ex_stall;
`else
   logic w_unused_ex;
   assign w_fwd_rs1   = 1'b0;
   assign w_fwd_rs2   = 1'b0;
   assign w_unused_ex = ^{bus.ex_rd_addr, bus.ex_we};
`endif

   // Forwarded sources are satisfied from EX; WAW on rd always blocks
   assign w_hazard = bus.iss_valid &
                     ((bus.iss_rs1_use & r_sb[bus.iss_rs1_addr] & ~w_fwd_rs1) |
                      (bus.iss_rs2_use & r_sb[bus.iss_rs2_addr] & ~w_fwd_rs2) |
                      (bus.iss_we      & r_sb[bus.iss_rd_addr]));

   assign w_redir_eff = (bus.redirect | r_pend) & ~w_ex_stall;
   assign w_iss_stall = w_hazard | w_ex_stall;
   assign w_accept    = bus.iss_valid & ~w_iss_stall & ~w_redir_eff;

   assign bus.iss_stall = w_iss_stall;
   assign bus.ex_stall  = w_ex_stall;
   assign bus.busy      = w_ex_stall;
   assign bus.ex_flush  = w_redir_eff | (w_hazard & ~w_ex_stall);
   assign bus.fwd_rs1   = w_fwd_rs1;
   assign bus.fwd_rs2   = w_fwd_rs2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pend  <= 1'b0;
         r_sb    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pend  <= w_pend_nxt;
         r_sb    <= w_sb_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = 1'b0;
      w_sb_nxt    = r_sb;

      case (r_state)
         IDLE: begin
            if (w_accept && bus.iss_multi) begin
               w_state_nxt = BUSY;
               w_cnt_nxt   = CNT_W'(MUL_LAT - 1);
            end
         end
         BUSY: begin
            // A redirect seen while EX is occupied is held until the first IDLE cycle
            w_pend_nxt = r_pend | bus.redirect;
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // Retire first so a same-edge new write to the same register stays pending
      if (bus.wb_we) w_sb_nxt[bus.wb_rd_addr] = 1'b0;
      if (w_accept && bus.iss_we) w_sb_nxt[bus.iss_rd_addr] = 1'b1;
   end

endmodule

// File: tb/tb_iss_hazard_ctrl.sv
// Self-checking bench for iss_hazard_ctrl: directed scenarios plus random
// traffic checked against a cycle-level behavioural model of the controller.
module tb_iss_hazard_ctrl;

   localparam int unsigned MUL_LAT = 4;

   typedef struct {
      logic       v;
      logic [3:0] a1, a2, ad;
      logic       u1, u2, we, mu;
      logic [3:0] exd;
      logic       exw;
      logic       wbw;
      logic [3:0] wbd;
      logic       rdr;
   } stim_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   // behavioural model: pending-write set, remaining EX-busy cycles, held redirect
   bit [15:0] m_sb;
   int        m_left;
   bit        m_pend;

   logic obs_busy;
   logic obs_flush;
   logic obs_stall;

   iss_hazard_ctrl_if bus ();

   iss_hazard_ctrl #(.DATA_WIDTH(32), .MUL_LAT(MUL_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply(input stim_t s);
      bus.iss_valid    = s.v;
      bus.iss_rs1_addr = s.a1;
      bus.iss_rs2_addr = s.a2;
      bus.iss_rd_addr  = s.ad;
      bus.iss_rs1_use  = s.u1;
      bus.iss_rs2_use  = s.u2;
      bus.iss_we       = s.we;
      bus.iss_multi    = s.mu;
      bus.ex_rd_addr   = s.exd;
      bus.ex_we        = s.exw;
      bus.wb_we        = s.wbw;
      bus.wb_rd_addr   = s.wbd;
      bus.redirect     = s.rdr;
   endtask

   function automatic stim_t nop();
      stim_t s;
      s = '{v: 1'b0, a1: 4'd0, a2: 4'd0, ad: 4'd0, u1: 1'b0, u2: 1'b0, we: 1'b0,
            mu: 1'b0, exd: 4'd0, exw: 1'b0, wbw: 1'b0, wbd: 4'd0, rdr: 1'b0};
      return s;
   endfunction

   task automatic model_reset();
      m_sb   = '0;
      m_left = 0;
      m_pend = 1'b0;
   endtask

   // one cycle: drive at negedge, check combinational outputs, advance model at posedge
   task automatic step(input string tag, input stim_t s);
      bit e_busy, e_f1, e_f2, e_haz, e_redir, e_stall, e_flush, e_acc;
      @(negedge clk);
      apply(s);
      #1;
      e_busy = (m_left > 0);
`ifdef QTPA_FWD_EN
      e_f1 = s.u1 && s.exw && (s.exd == s.a1) && !e_busy;
      e_f2 = s.u2 && s.exw && (s.exd == s.a2) && !e_busy;
`else
      e_f1 = 1'b0;
      e_f2 = 1'b0;
`endif
      e_haz   = s.v && ((s.u1 && m_sb[s.a1] && !e_f1) ||
                        (s.u2 && m_sb[s.a2] && !e_f2) ||
                        (s.we && m_sb[s.ad]));
      e_redir = !e_busy && (s.rdr || m_pend);
      e_stall = e_haz || e_busy;
      e_flush = e_redir || (e_haz && !e_busy);
      e_acc   = s.v && !e_stall && !e_redir;

      chk({tag, ".iss_stall"}, 32'(bus.iss_stall), 32'(e_stall));
      chk({tag, ".ex_stall"},  32'(bus.ex_stall),  32'(e_busy));
      chk({tag, ".busy"},      32'(bus.busy),      32'(e_busy));
      chk({tag, ".ex_flush"},  32'(bus.ex_flush),  32'(e_flush));
      chk({tag, ".fwd_rs1"},   32'(bus.fwd_rs1),   32'(e_f1));
      chk({tag, ".fwd_rs2"},   32'(bus.fwd_rs2),   32'(e_f2));
      obs_busy  = bus.busy;
      obs_flush = bus.ex_flush;
      obs_stall = bus.iss_stall;

      @(posedge clk);
      if (s.wbw) m_sb[s.wbd] = 1'b0;
      if (e_acc && s.we) m_sb[s.ad] = 1'b1;
      m_pend = e_busy ? (m_pend || s.rdr) : 1'b0;
      if (e_busy) m_left = m_left - 1;
      else if (e_acc && s.mu) m_left = int'(MUL_LAT) - 1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".iss_stall"}, 32'(bus.iss_stall), 32'd0);
      chk({tag, ".ex_stall"},  32'(bus.ex_stall),  32'd0);
      chk({tag, ".ex_flush"},  32'(bus.ex_flush),  32'd0);
      chk({tag, ".fwd_rs1"},   32'(bus.fwd_rs1),   32'd0);
      chk({tag, ".fwd_rs2"},   32'(bus.fwd_rs2),   32'd0);
      chk({tag, ".busy"},      32'(bus.busy),      32'd0);
   endtask

   initial begin
      stim_t s;
      int    nbusy;
      total = 0;
      bad   = 0;
      model_reset();
      rst_n = 1'b0;
      apply(nop());
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // RAW on r3: producer, dependent held until r3 retires, then accepted
      s = nop(); s.v = 1; s.ad = 4'd3; s.we = 1;
      step("raw_issue", s);
      s = nop(); s.v = 1; s.a1 = 4'd3; s.u1 = 1; s.exd = 4'd3; s.exw = 1;
      step("raw_dep0", s);
`ifndef QTPA_FWD_EN
      chk("raw_dep0_stall", 32'(obs_stall), 32'd1);
      chk("raw_dep0_flush", 32'(obs_flush), 32'd1);
`endif
      s.exw = 0;
      step("raw_dep1", s);
      step("raw_dep2", s);
      s.wbw = 1; s.wbd = 4'd3;
      step("raw_wb", s);
      s.wbw = 0;
      step("raw_go", s);
      chk("raw_go_stall", 32'(obs_stall), 32'd0);

      // multi-cycle op occupies EX for MUL_LAT-1 cycles with no bubbles
      s = nop(); s.v = 1; s.mu = 1; s.ad = 4'd9;
      step("mul_issue", s);
      nbusy = 0;
      for (int i = 0; i < 5; i++) begin
         s = nop(); s.v = 1; s.a1 = 4'd1; s.u1 = 1;
         step("mul_run", s);
         if (obs_busy) nbusy++;
         chk("mul_noflush", 32'(obs_flush), 32'd0);
      end
      chk("mul_busy_cycles", 32'(nbusy), 32'(MUL_LAT - 1));

      // redirect during BUSY is deferred to the first IDLE cycle
      s = nop(); s.v = 1; s.mu = 1;
      step("rdr_issue", s);
      step("rdr_busy1", nop());
      s = nop(); s.rdr = 1;
      step("rdr_busy2", s);
      chk("rdr_busy2_flush", 32'(obs_flush), 32'd0);
      step("rdr_busy3", nop());
      s = nop(); s.v = 1; s.ad = 4'd12; s.we = 1;
      step("rdr_idle1", s);
      chk("rdr_idle1_flush", 32'(obs_flush), 32'd1);
      step("rdr_idle2", nop());
      chk("rdr_idle2_flush", 32'(obs_flush), 32'd0);

      // same-edge set and clear of r5: set wins
      s = nop(); s.v = 1; s.ad = 4'd5; s.we = 1; s.wbw = 1; s.wbd = 4'd5;
      step("sb5_setclr", s);
      s = nop(); s.v = 1; s.a1 = 4'd5; s.u1 = 1;
      step("sb5_check", s);
      chk("sb5_pending", 32'(obs_stall), 32'd1);
      s = nop(); s.wbw = 1; s.wbd = 4'd5;
      step("sb5_retire", s);

      // async reset mid-BUSY with r4..r7 pending
      for (int r = 4; r < 8; r++) begin
         s = nop(); s.v = 1; s.ad = 4'(r); s.we = 1;
         step("fill_sb", s);
      end
      s = nop(); s.v = 1; s.mu = 1;
      step("rst_mul", s);
      step("rst_busy", nop());
      @(negedge clk);
      apply(nop());
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      s = nop(); s.v = 1; s.a1 = 4'd4; s.u1 = 1; s.a2 = 4'd7; s.u2 = 1; s.ad = 4'd6; s.we = 1;
      step("post_rst", s);
      chk("post_rst_stall", 32'(obs_stall), 32'd0);

      // random traffic against the model
      for (int n = 0; n < 400; n++) begin
         s.v   = ($urandom_range(3) != 0);
         s.a1  = 4'($urandom_range(15));
         s.a2  = 4'($urandom_range(15));
         s.ad  = 4'($urandom_range(15));
         s.u1  = 1'($urandom_range(1));
         s.u2  = 1'($urandom_range(1));
         s.we  = 1'($urandom_range(1));
         s.mu  = ($urandom_range(7) == 0);
         s.exd = 4'($urandom_range(15));
         s.exw = 1'($urandom_range(1));
         s.wbw = ($urandom_range(2) != 0);
         s.wbd = 4'($urandom_range(15));
         s.rdr = ($urandom_range(9) == 0);
         step("rand", s);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iss_hazard_ctrl.md
ISS_HAZARD_CTRL -- requirements
Module: iss_hazard_ctrl

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, qtpa_pkg value, carried for package consistency only.
REQ-002 SHALL have parameter: MUL_LAT, 4, EX occupancy in cycles of a multi-cycle op; legal range 2..15.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports: iss_valid  in  1  issue stage holds a valid instruction.
REQ-006 SHALL have ports: iss_rs1_addr, iss_rs2_addr, iss_rd_addr  in  4 each  issue-stage register addresses.
REQ-007 SHALL have ports: iss_rs1_use, iss_rs2_use, iss_we  in  1 each  source-read and dest-write flags.
REQ-008 SHALL have ports: iss_multi  in  1  issuing op is multi-cycle (e.g. MUL).
REQ-009 SHALL have ports: ex_rd_addr  in  4, ex_we  in  1  current EX-stage destination.
REQ-010 SHALL have ports: wb_we  in  1, wb_rd_addr  in  4  register-file write retiring a destination.
REQ-011 SHALL have ports: redirect  in  1  control-flow redirect resolved in EX.
REQ-012 SHALL have ports: iss_stall  out  1  hold issue stage and upstream.
REQ-013 SHALL have ports: ex_stall  out  1  drives ISS/EX pipeline register stall.
REQ-014 SHALL have ports: ex_flush  out  1  drives ISS/EX pipeline register flush (bubble).
REQ-015 SHALL have ports: fwd_rs1, fwd_rs2  out  1 each  select EX result instead of register-file data.
REQ-016 SHALL have ports: busy  out  1  FSM in BUSY.

Function
REQ-017 SHALL keep a 16-bit scoreboard sb, one pending-write bit per register.
REQ-018 SHALL define accept = iss_valid & ~iss_stall & ~redir_eff; on accept with iss_we, set sb[iss_rd_addr] next edge.
REQ-019 SHALL clear sb[wb_rd_addr] on wb_we; same-edge set and clear of the same bit -> set wins; clear of a zero bit is a no-op.
REQ-020 SHALL compute hazard = iss_valid & ((iss_rs1_use & sb[rs1] & ~fwd_rs1) | (iss_rs2_use & sb[rs2] & ~fwd_rs2) | (iss_we & sb[rd])), WAW included.
REQ-021 SHALL implement FSM IDLE/BUSY: IDLE->BUSY on accept with iss_multi, loading cnt = MUL_LAT-1; BUSY decrements cnt each cycle; BUSY->IDLE when cnt reaches 1.
REQ-022 SHALL drive ex_stall = (state==BUSY), busy = ex_stall, iss_stall = hazard | ex_stall; all outputs combinational from registered state and inputs, zero latency.
REQ-023 SHALL drive ex_flush = redir_eff | (hazard & ~ex_stall), inserting exactly one bubble per hazard cycle; never assert ex_flush and ex_stall together.
REQ-024 SHALL define redir_eff = redirect & IDLE, or pending flag in IDLE; redirect in BUSY sets pending, applied in first IDLE cycle then cleared.
REQ-025 SHALL not update sb on the instruction killed by redir_eff; existing sb bits are untouched by redirect.

Reset
REQ-026 SHALL on rst_n low asynchronously force sb=0, state=IDLE, cnt=0, pending=0; with iss_valid=0 all outputs then read 0.
REQ-027 SHALL discard an in-progress BUSY count and pending redirect on reset; first post-reset edge behaves as IDLE.

Configuration
REQ-028 SHALL with QTPA_FWD_EN defined assert fwd_rsN = iss_rsN_use & ex_we & (ex_rd_addr==iss_rsN_addr) & ~busy, suppressing that source's RAW stall.
REQ-029 SHALL with QTPA_FWD_EN undefined tie fwd_rs1/fwd_rs2 to 0, so RAW stalls persist until wb_we clears the bit.

Verification
REQ-030 SHALL cover RAW, no macro: issue rd=3 we, next cycle rs1=3 -> iss_stall=1, ex_flush=1 until wb_we rd=3, then accept the following cycle.
REQ-031 SHALL cover RAW with QTPA_FWD_EN: same sequence -> fwd_rs1=1, iss_stall=0, no bubble.
REQ-032 SHALL cover MUL_LAT=4 multi op accept -> ex_stall=busy=1 for exactly 3 cycles, then IDLE; ex_flush=0 throughout.
REQ-033 SHALL cover redirect in 2nd BUSY cycle -> no flush while BUSY, ex_flush=1 in first IDLE cycle only.
REQ-034 SHALL cover same-edge accept rd=5 we and wb_we rd=5 -> sb[5]=1 afterward.
REQ-035 SHALL cover rst_n low mid-BUSY with sb=0x00F0 -> sb=0, busy=0, all outputs 0 immediately, without waiting for clk.
